// File: rtl/uart_core_sched_pkg.sv
// Shared types and register map for the uart_core transmit/receive sequencer.
package uart_core_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_POLL_RD,
    S_POLL_WAIT,
    S_TX_WR,
    S_RX_RD,
    S_RX_WAIT,
    S_RX_GUARD
  } sched_state_t;

  localparam logic [3:0] ADDR_TXDATA = 4'h0;
  localparam logic [3:0] ADDR_STATUS = 4'h1;
  localparam logic [3:0] ADDR_RXDATA = 4'h2;

  localparam int STATUS_TX_READY_BIT = 0;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after
// the pointer, scanning upward and wrapping.
module rr_arbiter #(
  parameter int N     = 2,
  parameter int PTR_W = 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic             any_req_o
);

  logic             found;
  logic [PTR_W-1:0] idx;

  // Scan from the pointer position and keep only the first hit.
  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      idx = PTR_W'((int'(ptr_i) + i) % N);
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  assign any_req_o = |req_i;

endmodule

// File: rtl/uart_core_sched.sv
// Avalon-MM master that sequences one uart_core: polls STATUS, writes
// round-robin granted TX bytes to TXDATA, and drains RXDATA on interrupt.
module uart_core_sched #(
  parameter int NUM_SRC = 2,
  parameter int ADDR_W  = 4
) (
  input  logic                 clk_i,
  input  logic                 arst_n_i,
  input  logic [NUM_SRC-1:0]   src_valid_i,
  input  logic [NUM_SRC*8-1:0] src_data_i,
  output logic [NUM_SRC-1:0]   src_ready_o,
  output logic [7:0]           rx_data_o,
  output logic                 rx_valid_o,
  input  logic                 rx_ready_i,
  input  logic                 irq_i,
  output logic [ADDR_W-1:0]    avm_address_o,
  output logic                 avm_read_o,
  output logic                 avm_write_o,
  output logic [7:0]           avm_writedata_o,
  input  logic [7:0]           avm_readdata_i,
  output logic                 busy_o
);

  import uart_core_sched_pkg::*;

  localparam int IW = $clog2(NUM_SRC);

  sched_state_t   state_q, state_d;
  logic [IW-1:0]  ptr_q, ptr_d;
  logic [IW-1:0]  gnt_idx_q, gnt_idx_d;
  logic [7:0]     rx_data_q, rx_data_d;
  logic           rx_valid_q, rx_valid_d;

  logic [NUM_SRC-1:0] arb_gnt;
  logic               arb_any;
  logic [IW-1:0]      arb_idx;

  rr_arbiter #(
    .N     (NUM_SRC),
    .PTR_W (IW)
  ) u_arb (
    .req_i     (src_valid_i),
    .ptr_i     (ptr_q),
    .gnt_o     (arb_gnt),
    .any_req_o (arb_any)
  );

  // Encode the one-hot grant so it can be latched and used as a data mux select.
  always_comb begin
    arb_idx = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (arb_gnt[i]) arb_idx = IW'(i);
    end
  end

  // Next-state and bus/handshake decode; strobes are pure functions of the
  // state so an asynchronous reset removes them at once.
  always_comb begin
    state_d         = state_q;
    ptr_d           = ptr_q;
    gnt_idx_d       = gnt_idx_q;
    rx_data_d       = rx_data_q;
    rx_valid_d      = rx_valid_q;
    avm_read_o      = 1'b0;
    avm_write_o     = 1'b0;
    avm_address_o   = '0;
    avm_writedata_o = '0;
    src_ready_o     = '0;

    if (rx_valid_q && rx_ready_i) rx_valid_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // A full RX buffer leaves the byte in the core until it drains.
        if (irq_i && !rx_valid_q) begin
          state_d = S_RX_RD;
        end else if (arb_any) begin
          gnt_idx_d = arb_idx;
          state_d   = S_POLL_RD;
        end
      end
      S_POLL_RD: begin
        avm_read_o    = 1'b1;
        avm_address_o = ADDR_W'(ADDR_STATUS);
        state_d       = S_POLL_WAIT;
      end
      S_POLL_WAIT: begin
        // A busy core drops the grant so IDLE can re-arbitrate (RX first).
        state_d = avm_readdata_i[STATUS_TX_READY_BIT] ? S_TX_WR : S_IDLE;
      end
      S_TX_WR: begin
        avm_write_o            = 1'b1;
        avm_address_o          = ADDR_W'(ADDR_TXDATA);
        avm_writedata_o        = src_data_i[{gnt_idx_q, 3'b000} +: 8];
        src_ready_o[gnt_idx_q] = 1'b1;
        ptr_d                  = (gnt_idx_q == IW'(NUM_SRC - 1)) ? '0 : gnt_idx_q + 1'b1;
        state_d                = S_IDLE;
      end
      S_RX_RD: begin
        avm_read_o    = 1'b1;
        avm_address_o = ADDR_W'(ADDR_RXDATA);
        state_d       = S_RX_WAIT;
      end
      S_RX_WAIT: begin
        rx_data_d  = avm_readdata_i;
        rx_valid_d = 1'b1;
        state_d    = S_RX_GUARD;
      end
      S_RX_GUARD: begin
        // Gives the core a cycle to deassert its level interrupt.
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, arbitration pointer, latched grant and RX holding register.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      gnt_idx_q  <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gnt_idx_q  <= gnt_idx_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  assign rx_data_o  = rx_data_q;
  assign rx_valid_o = rx_valid_q;
  assign busy_o     = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_core_sched.sv
// Directed bench for uart_core_sched with a small uart_core register model.
module tb_uart_core_sched;
  import uart_core_sched_pkg::*;

  logic        clk = 1'b0;
  logic        arst_n;
  logic [1:0]  src_valid;
  logic [15:0] src_data;
  logic [1:0]  src_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        irq;
  logic [3:0]  avm_addr;
  logic        avm_read;
  logic        avm_write;
  logic [7:0]  avm_wdata;
  logic [7:0]  rdata = 8'h00;
  logic        busy;

  always #5 clk = ~clk;

  uart_core_sched #(
    .NUM_SRC (2),
    .ADDR_W  (4)
  ) dut (
    .clk_i           (clk),
    .arst_n_i        (arst_n),
    .src_valid_i     (src_valid),
    .src_data_i      (src_data),
    .src_ready_o     (src_ready),
    .rx_data_o       (rx_data),
    .rx_valid_o      (rx_valid),
    .rx_ready_i      (rx_ready),
    .irq_i           (irq),
    .avm_address_o   (avm_addr),
    .avm_read_o      (avm_read),
    .avm_write_o     (avm_write),
    .avm_writedata_o (avm_wdata),
    .avm_readdata_i  (rdata),
    .busy_o          (busy)
  );

  // uart_core model: STATUS reads report busy until ok_from reads have
  // happened; RXDATA returns rx_byte; TXDATA writes are counted and logged.
  int         stat_reads = 0;
  int         rx_reads   = 0;
  int         wr_cnt     = 0;
  int         ok_from    = 0;
  logic [7:0] rx_byte    = 8'h00;
  logic [7:0] last_wr    = 8'h00;

  always @(posedge clk) begin
    rdata <= 8'h00;
    if (avm_read && avm_addr == ADDR_STATUS) begin
      rdata      <= (stat_reads >= ok_from) ? 8'h01 : 8'h00;
      stat_reads <= stat_reads + 1;
    end
    if (avm_read && avm_addr == ADDR_RXDATA) begin
      rdata    <= rx_byte;
      rx_reads <= rx_reads + 1;
    end
    if (avm_write && avm_addr == ADDR_TXDATA) begin
      last_wr <= avm_wdata;
      wr_cnt  <= wr_cnt + 1;
    end
  end

  // Source protocol: valid may only fall on or after its accept pulse.
  logic [1:0] prev_v = 2'b00;
  logic [1:0] prev_r = 2'b00;
  always @(posedge clk) begin
    if (arst_n) begin
      for (int i = 0; i < 2; i++) begin
        assert (!(prev_v[i] && !prev_r[i] && !src_valid[i] && !src_ready[i]))
          else $error("source %0d dropped valid before accept", i);
      end
    end
    prev_v <= src_valid;
    prev_r <= src_ready;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " read"},     32'(avm_read),  32'd0);
    check({tag, " write"},    32'(avm_write), 32'd0);
    check({tag, " addr"},     32'(avm_addr),  32'd0);
    check({tag, " wdata"},    32'(avm_wdata), 32'd0);
    check({tag, " ready"},    32'(src_ready), 32'd0);
    check({tag, " rx_valid"}, 32'(rx_valid),  32'd0);
    check({tag, " rx_data"},  32'(rx_data),   32'd0);
    check({tag, " busy"},     32'(busy),      32'd0);
  endtask

  typedef struct {
    logic [1:0] valid;
    logic [7:0] d0;
    logic [7:0] d1;
    int         busy_polls;
    logic [1:0] exp_rdy;
    logic [7:0] exp_data;
  } tx_vec_t;

  tx_vec_t vecs[10];

  initial begin
    int         s0, w0, r0, lat;
    logic [1:0] got_rdy;
    logic [7:0] got_wd;
    logic       got_wr;

    // Pointer value before each row is noted on the right.
    vecs[0] = '{2'b10, 8'h00, 8'h33, 0, 2'b10, 8'h33}; // ptr 1
    vecs[1] = '{2'b11, 8'hA1, 8'hB2, 0, 2'b01, 8'hA1}; // ptr 0
    vecs[2] = '{2'b11, 8'hA1, 8'hB2, 0, 2'b10, 8'hB2}; // ptr 1
    vecs[3] = '{2'b11, 8'hA1, 8'hB2, 0, 2'b01, 8'hA1}; // ptr 0
    vecs[4] = '{2'b11, 8'hA1, 8'hB2, 0, 2'b10, 8'hB2}; // ptr 1
    vecs[5] = '{2'b01, 8'hA1, 8'h00, 2, 2'b01, 8'hA1}; // ptr 0, core busy twice
    vecs[6] = '{2'b10, 8'h00, 8'h5C, 1, 2'b10, 8'h5C}; // ptr 1, core busy once
    vecs[7] = '{2'b10, 8'h00, 8'h0F, 0, 2'b10, 8'h0F}; // ptr 0, skip idle src0
    vecs[8] = '{2'b01, 8'h77, 8'h00, 0, 2'b01, 8'h77}; // ptr 0
    vecs[9] = '{2'b01, 8'h2D, 8'h00, 0, 2'b01, 8'h2D}; // ptr 1, wrap to src0

    arst_n    = 1'b0;
    src_valid = 2'b00;
    src_data  = 16'h0000;
    rx_ready  = 1'b0;
    irq       = 1'b0;

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    arst_n = 1'b1;

    // Single source, core ready: poll at cycle 1, write at cycle 3.
    @(negedge clk);
    s0 = stat_reads; w0 = wr_cnt; ok_from = stat_reads;
    src_data  = {8'h00, 8'h48};
    src_valid = 2'b01;
    @(negedge clk);
    check("single c1 read",  32'(avm_read),  32'd1);
    check("single c1 addr",  32'(avm_addr),  32'(ADDR_STATUS));
    check("single c1 ready", 32'(src_ready), 32'd0);
    @(negedge clk);
    check("single c2 read",  32'(avm_read),  32'd0);
    check("single c2 ready", 32'(src_ready), 32'd0);
    check("single c2 busy",  32'(busy),      32'd1);
    @(negedge clk);
    check("single c3 write", 32'(avm_write), 32'd1);
    check("single c3 addr",  32'(avm_addr),  32'(ADDR_TXDATA));
    check("single c3 wdata", 32'(avm_wdata), 32'h48);
    check("single c3 ready", 32'(src_ready), 32'b01);
    src_valid = 2'b00;
    @(negedge clk);
    check("single c4 busy",  32'(busy),      32'd0);
    check("single c4 ready", 32'(src_ready), 32'd0);
    check("single polls",    32'(stat_reads - s0), 32'd1);
    check("single writes",   32'(wr_cnt - w0),     32'd1);
    check("single logged",   32'(last_wr),         32'h48);

    // Table: round-robin order, busy-core retries, pointer wrap.
    for (int r = 0; r < 10; r++) begin
      s0 = stat_reads; w0 = wr_cnt;
      ok_from   = stat_reads + vecs[r].busy_polls;
      src_data  = {vecs[r].d1, vecs[r].d0};
      src_valid = vecs[r].valid;
      lat = 0; got_rdy = 2'b00; got_wd = 8'h00; got_wr = 1'b0;
      for (int c = 1; c <= 60; c++) begin
        @(negedge clk);
        if (src_ready != 2'b00) begin
          lat = c; got_rdy = src_ready; got_wd = avm_wdata; got_wr = avm_write;
          break;
        end
      end
      src_valid = src_valid & ~got_rdy;
      check($sformatf("row%0d latency", r), 32'(lat),     32'(3 * vecs[r].busy_polls + 3));
      check($sformatf("row%0d ready", r),   32'(got_rdy), 32'(vecs[r].exp_rdy));
      check($sformatf("row%0d wdata", r),   32'(got_wd),  32'(vecs[r].exp_data));
      check($sformatf("row%0d write", r),   32'(got_wr),  32'd1);
      check($sformatf("row%0d polls", r),   32'(stat_reads - s0), 32'(vecs[r].busy_polls + 1));
      @(negedge clk);
      check($sformatf("row%0d writes", r),  32'(wr_cnt - w0), 32'd1);
      check($sformatf("row%0d logged", r),  32'(last_wr),     32'(vecs[r].exp_data));
    end

    // RX priority: irq and src_valid together, RX is served first.
    rx_byte = 8'h6E; r0 = rx_reads; ok_from = stat_reads;
    src_data  = {8'h00, 8'hC4};
    src_valid = 2'b01;
    irq       = 1'b1;
    @(negedge clk);
    check("rxpri c1 read", 32'(avm_read), 32'd1);
    check("rxpri c1 addr", 32'(avm_addr), 32'(ADDR_RXDATA));
    @(negedge clk);
    check("rxpri c2 rx_valid", 32'(rx_valid), 32'd0);
    irq = 1'b0;
    @(negedge clk);
    check("rxpri c3 rx_valid", 32'(rx_valid), 32'd1);
    check("rxpri c3 rx_data",  32'(rx_data),  32'h6E);
    check("rxpri c3 busy",     32'(busy),     32'd1);
    @(negedge clk);
    check("rxpri c4 busy",     32'(busy),     32'd0);
    check("rxpri rx reads",    32'(rx_reads - r0), 32'd1);
    @(negedge clk);
    check("rxpri c5 read", 32'(avm_read), 32'd1);
    check("rxpri c5 addr", 32'(avm_addr), 32'(ADDR_STATUS));
    @(negedge clk);
    @(negedge clk);
    check("rxpri c7 write", 32'(avm_write), 32'd1);
    check("rxpri c7 wdata", 32'(avm_wdata), 32'hC4);
    check("rxpri c7 ready", 32'(src_ready), 32'b01);
    src_valid = 2'b00;
    @(negedge clk);

    // RX backpressure: buffer full, irq high again; TX must still proceed.
    rx_byte = 8'h91; r0 = rx_reads; ok_from = stat_reads;
    irq       = 1'b1;
    src_data  = {8'hE5, 8'h00};
    src_valid = 2'b10;
    lat = 0; got_rdy = 2'b00; got_wd = 8'h00;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (src_ready != 2'b00) begin
        lat = c; got_rdy = src_ready; got_wd = avm_wdata;
        break;
      end
    end
    src_valid = src_valid & ~got_rdy;
    check("bp tx latency",  32'(lat),      32'd3);
    check("bp tx ready",    32'(got_rdy),  32'b10);
    check("bp tx wdata",    32'(got_wd),   32'hE5);
    check("bp no rx read",  32'(rx_reads - r0), 32'd0);
    check("bp held valid",  32'(rx_valid), 32'd1);
    check("bp held data",   32'(rx_data),  32'h6E);
    @(negedge clk);
    rx_ready = 1'b1;
    @(negedge clk);
    check("bp drained", 32'(rx_valid), 32'd0);
    rx_ready = 1'b0;
    @(negedge clk);
    check("bp rx read",  32'(avm_read), 32'd1);
    check("bp rx addr",  32'(avm_addr), 32'(ADDR_RXDATA));
    @(negedge clk);
    irq = 1'b0;
    @(negedge clk);
    check("bp second valid", 32'(rx_valid), 32'd1);
    check("bp second data",  32'(rx_data),  32'h91);
    check("bp rx reads",     32'(rx_reads - r0), 32'd1);
    @(negedge clk);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    check("bp final drain", 32'(rx_valid), 32'd0);

    // Reset asserted during TX_WR, then a fresh poll after release.
    s0 = stat_reads; w0 = wr_cnt; ok_from = stat_reads;
    src_data  = {8'h00, 8'h3C};
    src_valid = 2'b01;
    repeat (3) @(negedge clk);
    check("rst pre write", 32'(avm_write), 32'd1);
    arst_n = 1'b0;
    #1;
    check_all_zero("rst mid");
    @(negedge clk);
    check("rst no write", 32'(wr_cnt - w0), 32'd0);
    arst_n = 1'b1;
    @(negedge clk);
    check("rst post read",  32'(avm_read),  32'd1);
    check("rst post addr",  32'(avm_addr),  32'(ADDR_STATUS));
    check("rst post write", 32'(avm_write), 32'd0);
    @(negedge clk);
    @(negedge clk);
    check("rst post ready", 32'(src_ready), 32'b01);
    check("rst post wdata", 32'(avm_wdata), 32'h3C);
    src_valid = 2'b00;
    @(negedge clk);
    check("rst writes", 32'(wr_cnt - w0),     32'd1);
    check("rst logged", 32'(last_wr),         32'h3C);
    check("rst polls",  32'(stat_reads - s0), 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_core_sched.md
# uart_core_sched

Avalon-MM master that sequences a single `uart_core` instance on behalf of several byte-stream producers and one byte-stream consumer. It polls the core's STATUS register, writes granted transmit bytes to TXDATA under round-robin arbitration, and drains received bytes from the RX register when the core raises its interrupt. It sits between the system's message sources and `uart_core`, so no source ever drives the core's register port directly.

## Interface
- `NUM_SRC`, 2: number of transmit requesters, 2..8.
- `ADDR_W`, 4: Avalon address width, matching `uart_core`.
- `clk_i` in 1: system clock.
- `arst_n_i` in 1: reset, asynchronous, active-low.
- `src_valid_i` in NUM_SRC: per-source byte pending.
- `src_data_i` in NUM_SRC×8: per-source byte. Must be held stable while valid.
- `src_ready_o` out NUM_SRC: one-cycle accept pulse, one-hot.
- `rx_data_o` out 8: received byte.
- `rx_valid_o` out 1: rx_data_o holds a byte.
- `rx_ready_i` in 1: consumer accepts the byte.
- `irq_i` in 1: `uart_core` IRQ_event (level).
- `avm_address_o` out ADDR_W: core register address.
- `avm_read_o` out 1: read strobe.
- `avm_write_o` out 1: write strobe.
- `avm_writedata_o` out 8: write data.
- `avm_readdata_i` in 8: read data. Valid in the cycle after `avm_read_o`.
- `busy_o` out 1: FSM is not in IDLE.

## Operation
- Register map: TXDATA=4'h0, STATUS=4'h1 (bit0 = transmitter ready), RXDATA=4'h2.
- FSM states:
  - IDLE
  - POLL_RD
  - POLL_WAIT
  - TX_WR
  - RX_RD
  - RX_WAIT
  - RX_GUARD
- IDLE priority is RX first.
  - If `irq_i` is high and `rx_valid_o` is 0, go to RX_RD.
  - Otherwise, if any `src_valid_i` is high, latch the round-robin grant index and go to POLL_RD.
  - Otherwise, stay in IDLE.
- POLL_RD: drive `avm_read_o`=1 and `avm_address_o`=STATUS for one cycle, then go to POLL_WAIT.
- POLL_WAIT: sample `avm_readdata_i[0]`.
  - If 1, go to TX_WR.
  - If 0, go to IDLE. The grant is dropped and re-arbitrated, so a pending RX is served first.
- TX_WR: for one cycle, drive `avm_write_o`=1, `avm_address_o`=TXDATA, `avm_writedata_o`=`src_data_i[grant]`, and `src_ready_o[grant]`=1.
  - Set the round-robin pointer to grant+1, wrapping NUM_SRC-1 → 0.
  - Go to IDLE.
- RX_RD: drive `avm_read_o`=1 and `avm_address_o`=RXDATA for one cycle.
- RX_WAIT: register `avm_readdata_i` into `rx_data_o` and set `rx_valid_o`=1.
- RX_GUARD: one cycle with `irq_i` ignored, so the core can clear IRQ; then go to IDLE.
- RX buffer:
  - `rx_valid_o` clears on the cycle where `rx_valid_o & rx_ready_i`.
  - While the buffer is full, `irq_i` is not serviced and the byte stays in the core.
- Round-robin: the grant is the first valid source at or after the pointer, scanning upward with wrap. The pointer changes only on a completed TX_WR.
- A source dropping `src_valid_i` before its accept is a protocol violation. Behaviour is undefined. A bench assertion flags it.
- When not driven, `avm_read_o`/`avm_write_o` are 0, and address and writedata hold 0.

## Timing
- All outputs reset to 0: strobes, address, writedata, `src_ready_o`, `rx_data_o`, `rx_valid_o`, `busy_o`. State resets to IDLE and the pointer to 0.
- TX latency from `src_valid_i` seen in IDLE (cycle 0) with the core ready:
  - read strobe in cycle 1
  - status sampled in cycle 2
  - write strobe and `src_ready_o` in cycle 3
  - back in IDLE at cycle 4
- Minimum 4 cycles per transmitted byte. A failed poll costs 3 cycles.
- RX latency from `irq_i` seen in IDLE (cycle 0):
  - read in cycle 1
  - `rx_valid_o`=1 from cycle 3
  - IDLE at cycle 4
- Simultaneous `irq_i` and `src_valid_i` in IDLE: RX wins.
- Simultaneous `rx_ready_i` and a new capture cannot occur: capture requires an empty buffer.
- Reset asserted mid-operation: outputs clear immediately (asynchronous). No partial write is repeated after reset.

## Structure
- Package `uart_core_sched_pkg` holds:
  - state enum `sched_state_t`
  - localparams `ADDR_TXDATA`, `ADDR_STATUS`, `ADDR_RXDATA`, `STATUS_TX_READY_BIT`
- Sub-module `rr_arbiter #(N)` is combinational. Inputs are the request vector and pointer. Outputs are the one-hot grant and `any_req`.
- The pointer register and FSM live in the top level.

## Test plan
- **Single source:** src0 sends 8'h48 with the core ready → one STATUS read, then a TXDATA write of 8'h48 at cycle 3; `src_ready_o`=2'b01 for exactly one cycle.
- **Round-robin:** both sources hold valid with 8'hA1/8'hB2 (src0/src1) for 4 bytes → writes alternate A1, B2, A1, B2.
- **Core busy:** the STATUS bit0 model returns 0 twice, then 1 → three poll reads, one write, no early `src_ready_o`.
- **RX priority:** `irq_i` and `src_valid_i` rise in the same cycle, with the model RXDATA=8'h6E:
  - RXDATA is read first, and `rx_data_o`=8'h6E with `rx_valid_o`=1.
  - The TX write follows.
- **RX backpressure:** `rx_ready_i`=0 with a held byte and `irq_i` high again → no second RXDATA read until `rx_ready_i` is pulsed; TX continues meanwhile.
- **Reset mid-write:** `arst_n_i` is pulled low during TX_WR → all outputs 0 in the same cycle; after release, the first transaction is a fresh STATUS poll.
